// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock controller.
package lock_pkg;

    localparam int unsigned DIGIT_W = 2;

    typedef enum logic [2:0] {
        StInit    = 3'd0,
        StProgram = 3'd1,
        StLocked  = 3'd2,
        StEntry   = 3'd3,
        StCheck   = 3'd4,
        StOpen    = 3'd5,
        StLockout = 3'd6
    } state_e;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lock_timer #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             input_reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge input_reset) begin
        if (!input_reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Keypad lock controller: sequences the password checker and drives unlock, alarm and lockout.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned UNLOCK_CYCLES  = 1000,
    parameter int unsigned LOCKOUT_CYCLES = 5000,
    parameter int unsigned RESULT_WAIT    = 2
) (
    input  logic               clk,
    input  logic               input_reset,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_bits,
    input  logic               key_enter,
    input  logic               key_program,
    input  logic               correct_password,
    input  logic               incorrect_password,
    output logic [DIGIT_W-1:0] chk_bits,
    output logic               input_value,
    output logic               store_value,
    output logic               compare,
    output logic               chk_input_rst_n,
    output logic               chk_system_rst_n,
    output logic               unlock,
    output logic               alarm,
    output logic [2:0]         state,
    output logic [1:0]         attempts_left
);

    localparam int unsigned TimerMax0 =
        (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TimerMax  = (TimerMax0 > RESULT_WAIT) ? TimerMax0 : RESULT_WAIT;
    localparam int unsigned TimerW    = $clog2(TimerMax + 1);
    localparam int unsigned CntW      = $clog2(MAX_LEN + 1);
    localparam logic [1:0]  AttInit   = 2'(MAX_ATTEMPTS);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic [DIGIT_W-1:0]   bits_q, bits_d;
    logic                 input_value_q, input_value_d;
    logic                 store_value_q, store_value_d;
    logic                 compare_q, compare_d;
    logic                 in_rst_n_q, in_rst_n_d;
    logic                 sys_rst_n_q, sys_rst_n_d;
    logic                 unlock_q, unlock_d;
    logic                 alarm_q, alarm_d;
    logic [1:0]           att_q, att_d;
    logic                 tmr_load;
    logic [TimerW-1:0]    tmr_value;
    logic                 tmr_done;
    logic                 digit_ok;
    logic                 enter_ok;

    // A pending strobe blocks all keys; a digit on the same cycle as enter wins.
    assign digit_ok = key_valid && !pend_q && (cnt_q < CntW'(MAX_LEN));
    assign enter_ok = key_enter && !key_valid && !pend_q && (cnt_q != '0);

    lock_timer #(
        .WIDTH (TimerW)
    ) u_timer (
        .clk         (clk),
        .input_reset (input_reset),
        .load        (tmr_load),
        .load_value  (tmr_value),
        .done        (tmr_done)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_d        = 1'b0;
        bits_d        = bits_q;
        input_value_d = 1'b0;
        store_value_d = 1'b0;
        compare_d     = 1'b0;
        in_rst_n_d    = 1'b1;
        sys_rst_n_d   = 1'b1;
        unlock_d      = unlock_q;
        alarm_d       = alarm_q;
        att_d         = att_q;
        tmr_load      = 1'b0;
        tmr_value     = '0;

        if (pend_q) begin
            if (state_q == StProgram) begin
                store_value_d = 1'b1;
            end else begin
                input_value_d = 1'b1;
            end
        end

        unique case (state_q)
            StInit: state_d = StProgram;
            StProgram, StEntry: begin
                if (digit_ok) begin
                    bits_d = key_bits;
                    pend_d = 1'b1;
                    cnt_d  = cnt_q + CntW'(1);
                end else if (enter_ok) begin
                    cnt_d = '0;
                    if (state_q == StProgram) begin
                        state_d = StLocked;
                    end else begin
                        state_d   = StCheck;
                        compare_d = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_value = TimerW'(RESULT_WAIT);
                    end
                end
            end
            StLocked: begin
                if (digit_ok) begin
                    state_d = StEntry;
                    bits_d  = key_bits;
                    pend_d  = 1'b1;
                    cnt_d   = CntW'(1);
                end
            end
            StCheck: begin
                if (tmr_done) begin
                    in_rst_n_d = 1'b0;
                    cnt_d      = '0;
                    tmr_load   = 1'b1;
                    if (correct_password && !incorrect_password) begin
                        state_d   = StOpen;
                        unlock_d  = 1'b1;
                        att_d     = AttInit;
                        tmr_value = TimerW'(UNLOCK_CYCLES - 1);
                    end else if (att_q <= 2'd1) begin
                        state_d   = StLockout;
                        alarm_d   = 1'b1;
                        att_d     = 2'd0;
                        tmr_value = TimerW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_d = StLocked;
                        att_d   = att_q - 2'd1;
                    end
                end
            end
            StOpen: begin
                if (key_program) begin
                    state_d     = StProgram;
                    sys_rst_n_d = 1'b0;
                    unlock_d    = 1'b0;
                    cnt_d       = '0;
                end else if (tmr_done) begin
                    state_d  = StLocked;
                    unlock_d = 1'b0;
                end
            end
            StLockout: begin
                if (tmr_done) begin
                    state_d = StLocked;
                    alarm_d = 1'b0;
                    att_d   = AttInit;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge input_reset) begin
        if (!input_reset) begin
            state_q       <= StInit;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            bits_q        <= '0;
            input_value_q <= 1'b0;
            store_value_q <= 1'b0;
            compare_q     <= 1'b0;
            in_rst_n_q    <= 1'b0;
            sys_rst_n_q   <= 1'b0;
            unlock_q      <= 1'b0;
            alarm_q       <= 1'b0;
            att_q         <= AttInit;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            bits_q        <= bits_d;
            input_value_q <= input_value_d;
            store_value_q <= store_value_d;
            compare_q     <= compare_d;
            in_rst_n_q    <= in_rst_n_d;
            sys_rst_n_q   <= sys_rst_n_d;
            unlock_q      <= unlock_d;
            alarm_q       <= alarm_d;
            att_q         <= att_d;
        end
    end

    assign chk_bits         = bits_q;
    assign input_value      = input_value_q;
    assign store_value      = store_value_q;
    assign compare          = compare_q;
    assign chk_input_rst_n  = in_rst_n_q;
    assign chk_system_rst_n = sys_rst_n_q;
    assign unlock           = unlock_q;
    assign alarm            = alarm_q;
    assign state            = state_q;
    assign attempts_left    = att_q;

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
Top-level controller for the keypad lock. It accepts debounced keypad events and sequences the password-checker datapath: programming the stored code, capturing entered digits, triggering the compare, and reading the result. It drives the lock actuator, the alarm, and an attempt-limited lockout. It is fully synchronous on clk and generates every checker strobe and checker reset as a registered, glitch-free signal.

Parameters:
MAX_LEN, 4, maximum digits per code; extra digits are ignored.
MAX_ATTEMPTS, 3, consecutive failed compares before lockout.
UNLOCK_CYCLES, 1000, cycles unlock stays high.
LOCKOUT_CYCLES, 5000, cycles alarm/lockout lasts.
RESULT_WAIT, 2, cycles between compare pulse and result sampling.

Ports:
clk  in  1  system clock
input_reset  in  1  reset, asynchronous, active-low
key_valid  in  1  one-cycle pulse, digit present on key_bits
key_bits  in  2  digit value
key_enter  in  1  one-cycle pulse, end of code
key_program  in  1  one-cycle pulse, request new code
correct_password  in  1  checker result
incorrect_password  in  1  checker result
chk_bits  out  2  digit to checker, registered
input_value  out  1  strobe: checker captures entered digit
store_value  out  1  strobe: checker captures stored digit
compare  out  1  strobe: checker compares
chk_input_rst_n  out  1  clears checker entry buffer, active-low
chk_system_rst_n  out  1  clears whole checker, active-low
unlock  out  1  actuator enable
alarm  out  1  high during lockout
state  out  3  current state encoding, for debug
attempts_left  out  2  remaining tries

Behaviour:
- Reset (input_reset low, async): state=INIT; chk_bits=0; input_value, store_value, compare, unlock, alarm = 0; chk_input_rst_n=0, chk_system_rst_n=0; digit count=0; attempts_left=MAX_ATTEMPTS.
- INIT: hold both checker resets low for 1 cycle after reset release, then release them and go to PROGRAM.
- PROGRAM: on key_valid with count<MAX_LEN, register chk_bits=key_bits; one cycle later pulse store_value for 1 cycle; count++. key_valid at count==MAX_LEN is ignored. key_enter with count>=1 goes to LOCKED and clears count. key_enter with count==0 is ignored.
- LOCKED: first accepted key_valid goes to ENTRY and is handled as an ENTRY digit. key_program is ignored.
- ENTRY: digit handling as in PROGRAM, but pulses input_value instead of store_value. key_enter with count>=1 goes to CHECK. key_enter with count==0 is ignored.
- CHECK: pulse compare for 1 cycle (tied to no digit strobe), wait RESULT_WAIT cycles, then sample the checker results.
  - correct=1 and incorrect=0: go to OPEN; attempts_left=MAX_ATTEMPTS.
  - Any other combination (incorrect, both 0, both 1) is a fail: attempts_left--.
  - On fail, go to LOCKOUT if attempts_left reaches 0, else to LOCKED.
  - In every exit case, pulse chk_input_rst_n low for 1 cycle and clear count.
- OPEN: unlock=1 for UNLOCK_CYCLES, then unlock=0 and go to LOCKED. key_program in OPEN pulses chk_system_rst_n low for 1 cycle, drops unlock, and goes to PROGRAM.
- LOCKOUT: alarm=1 for LOCKOUT_CYCLES; all keys ignored. On expiry: alarm=0, attempts_left=MAX_ATTEMPTS, go to LOCKED.
- Simultaneous key_valid and key_enter: the digit is taken and enter is dropped. key_program simultaneous with either is honoured only in OPEN and overrides them.
- Keys arriving while a strobe is still pending (1 cycle) are dropped.
- chk_bits holds its value until the next accepted digit.
- At most one of input_value, store_value, compare is high in any cycle.
- Reset mid-operation returns to INIT and re-clears the checker; the stored code is lost.
- Latency: key_valid to digit strobe = 2 cycles. key_enter to compare = 1 cycle. compare to unlock/alarm = RESULT_WAIT+1 cycles.

Decomposition:
- Package lock_pkg holds:
  - state enum: INIT=0, PROGRAM=1, LOCKED=2, ENTRY=3, CHECK=4, OPEN=5, LOCKOUT=6.
  - Digit width constant DIGIT_W=2.
- One sub-module, lock_timer: a loadable down-counter with a done flag. It is shared by the CHECK wait, OPEN and LOCKOUT, and is sized to the largest parameter.

Test Plan:
- Reset, then program 1,2,3 + enter -> 3 store_value pulses with chk_bits 1,2,3; state=LOCKED.
- Enter 1,2,3 + enter with checker returning correct -> compare pulse; unlock high exactly UNLOCK_CYCLES; attempts_left=3.
- Three wrong codes -> attempts_left 2,1,0; alarm high LOCKOUT_CYCLES; keys ignored during lockout; then attempts_left=3.
- Enter 5 digits -> only 4 input_value pulses. Enter with zero digits -> no compare.
- key_program during OPEN -> chk_system_rst_n low 1 cycle, unlock drops, new 2-digit code stored.
- input_reset asserted mid-ENTRY -> all outputs at reset values immediately; both checker resets low; INIT then PROGRAM.
